pe_array_drain: RTL and testbench
=================================

Name: pe_array_drain

Overview:
Result-side controller for a row of multiply-accumulate processing elements. It counts operand beats into the PE row, captures the PE accumulator outputs when a tile completes, and clears the PEs. It then streams the captured results out one word at a time over a valid/ready interface. It sits between the PE row and the output writer/memory interface, and back-pressures the operand feeder while results are still draining.

Parameters:
DATA_WIDTH, 32, width of one PE accumulator / output word
NUM_PE, 4, number of PEs in the row (words per tile); >= 1
ACC_LEN, 8, operand beats accumulated per tile; >= 1
CNT_WIDTH, 8, width of the beat counter; must satisfy 2^CNT_WIDTH > ACC_LEN

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin a tile; sampled only in IDLE
in_valid  in  1  feeder presents one operand beat to all PEs this cycle
in_ready  out  1  beat accepted when in_valid && in_ready
pe_c  in  NUM_PE*DATA_WIDTH  PE accumulator outputs; PE i on bits [i*DATA_WIDTH +: DATA_WIDTH]
pe_clr  out  1  one-cycle clear pulse to all PE accumulators
out_valid  out  1  out_data holds a valid result word
out_ready  in  1  downstream accepts the word when out_valid && out_ready
out_data  out  DATA_WIDTH  result word
out_last  out  1  high with the final word (PE NUM_PE-1) of a tile
busy  out  1  high when state != IDLE or the shadow buffer is non-empty

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, beat_cnt=0, shadow buffer empty, rd_idx=0. in_ready=0, pe_clr=0, out_valid=0, out_data=0, out_last=0, busy=0. The shadow contents are don't-care but must be zeroed. Reset mid-tile or mid-drain discards everything and asserts no pe_clr.
- Control FSM states: IDLE, RUN, CAP.
  - IDLE: in_ready=0. If start=1, go to RUN and set beat_cnt=0.
  - RUN: in_ready=1. Each accepted beat increments beat_cnt. The beat that makes beat_cnt reach ACC_LEN moves the FSM to CAP. in_valid=0 just holds. start is ignored.
  - CAP: in_ready=0. pe_c now holds the full sum, because the PE register updates one edge after the beat. If the shadow buffer is free this cycle, pe_c is latched into the shadow on the clock edge. The buffer is free when it is empty, or when its last word handshakes in this same cycle. When that happens: shadow_full=1, rd_idx=0, beat_cnt=0, next state IDLE. Otherwise the FSM stays in CAP, holding pe_c and stalling the feeder.
- pe_clr: combinational, high exactly in the CAP cycle where capture occurs. It is never high in any other cycle, so the PE sees exactly one clear per tile.
- Drain:
  - out_valid = shadow_full.
  - out_data = shadow[rd_idx].
  - out_last = shadow_full && (rd_idx == NUM_PE-1).
  - On a handshake: if rd_idx < NUM_PE-1, increment rd_idx. Otherwise clear shadow_full and set rd_idx=0.
  - While out_valid=1 and out_ready=0, out_data and out_last are held stable.
  - out_valid never drops without a handshake.
- Simultaneous events: a final-word handshake and a capture in the same cycle are allowed. The new tile is latched, shadow_full stays 1, and rd_idx=0, giving back-to-back tiles with no bubble.
- Word order on the output: PE0 first through PE NUM_PE-1.
- Data is passed through unmodified, with no arithmetic on it, so the block works for both integer and float PEs.
- Latency: the first word is valid 1 cycle after the capture cycle. A tile with continuous in_valid and out_ready takes ACC_LEN+1 cycles of accumulation plus NUM_PE output cycles.
- NUM_PE=1: out_last=1 on every word.

Test Plan:
1. Basic tile. NUM_PE=4, ACC_LEN=3. Pulse start, then hold in_valid=1. pe_c={40,30,20,10} at the CAP cycle, out_ready=1.
   Required: in_ready is high for exactly 3 cycles; pe_clr is pulsed once in CAP; out_data is 10,20,30,40 on consecutive cycles; out_last is set on 40; busy=0 afterwards.
2. Feeder gaps. Use in_valid pattern 1,0,0,1,0,1.
   Required: CAP is entered only after the 3rd accepted beat; beat_cnt holds across the gaps.
3. Output backpressure. out_ready=0 for 5 cycles on word 20.
   Required: out_data=20 and out_valid=1 stay stable; a second tile's CAP stalls with in_ready=0 and no pe_clr until the last word handshakes.
4. Back-to-back tiles. Arrange for the second tile's CAP to coincide with the handshake of the first tile's last word.
   Required: capture occurs in that same cycle; the next cycle out_data is the second tile's PE0 word, with no idle cycle between tiles.
5. Reset mid-drain. After word 20 of a tile, drive rst=0 asynchronously, between clock edges.
   Required: out_valid, busy, in_ready and pe_clr go to 0 immediately; after release the FSM is IDLE and start begins a fresh tile.
6. start ignored outside IDLE. Assert start during RUN and during CAP.
   Required: no effect on beat_cnt or state, and exactly one tile is produced.

Source files
------------

// File: rtl/pe_array_drain.sv
// Result-side controller for a MAC PE row: counts operand beats, captures the PE accumulators, then streams them out.
// First word is valid one cycle after capture; the feeder is held off (in_ready=0) while the shadow buffer cannot take a new tile.
module pe_array_drain #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_PE     = 4,
   parameter int ACC_LEN    = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NUM_PE*DATA_WIDTH-1:0] pe_c,
   output logic                         pe_clr,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_last,
   output logic                         busy
);

   localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_PE - 1);
   localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(ACC_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      CAP  = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [CNT_WIDTH-1:0]   beat_cnt;
   logic [CNT_WIDTH-1:0]   beat_cnt_nxt;
   logic [DATA_WIDTH-1:0]  shadow [NUM_PE];
   logic                   shadow_full;
   logic [IDX_W-1:0]       rd_idx;
   logic                   out_hs;
   logic                   last_hs;
   logic                   capture;

   assign out_hs  = shadow_full && out_ready;
   assign last_hs = out_hs && (rd_idx == LAST_IDX);

   always_comb begin
      state_nxt    = state;
      beat_cnt_nxt = beat_cnt;
      in_ready     = 1'b0;
      capture      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt    = RUN;
               beat_cnt_nxt = '0;
            end
         end
         RUN: begin
            in_ready = 1'b1;
            if (in_valid) begin
               beat_cnt_nxt = beat_cnt + CNT_WIDTH'(1);
               if (beat_cnt == LAST_BEAT) begin
                  state_nxt = CAP;
               end
            end
         end
         CAP: begin
            // The shadow is free if empty or its final word leaves this very cycle.
            if (!shadow_full || last_hs) begin
               capture      = 1'b1;
               beat_cnt_nxt = '0;
               state_nxt    = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_full <= 1'b0;
         rd_idx      <= '0;
         for (int i = 0; i < NUM_PE; i++) begin
            shadow[i] <= '0;
         end
      end else if (capture) begin
         for (int i = 0; i < NUM_PE; i++) begin
            shadow[i] <= pe_c[i*DATA_WIDTH +: DATA_WIDTH];
         end
         shadow_full <= 1'b1;
         rd_idx      <= '0;
      end else if (out_hs) begin
         if (rd_idx == LAST_IDX) begin
            shadow_full <= 1'b0;
            rd_idx      <= '0;
         end else begin
            rd_idx <= rd_idx + IDX_W'(1);
         end
      end
   end

   assign pe_clr    = capture;
   assign out_valid = shadow_full;
   assign out_data  = shadow[rd_idx];
   assign out_last  = shadow_full && (rd_idx == LAST_IDX);
   assign busy      = (state != IDLE) || shadow_full;

   assert property (@(posedge clk) disable iff (!rst)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));

   assert property (@(posedge clk) disable iff (!rst)
      pe_clr |-> (state == CAP));

endmodule

// File: tb/tb_pe_array_drain.sv
// Scoreboard bench for pe_array_drain with a behavioural PE row accumulating the driven operands.
module tb_pe_array_drain;

   localparam int DW = 32;
   localparam int NP = 4;
   localparam int AL = 3;
   localparam int CW = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic [NP*DW-1:0] pe_c;
   logic             pe_clr;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_data;
   logic             out_last;
   logic             busy;

   pe_array_drain #(
      .DATA_WIDTH (DW),
      .NUM_PE     (NP),
      .ACC_LEN    (AL),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pe_c      (pe_c),
      .pe_clr    (pe_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural PE row: accumulate on accepted beats, clear on pe_clr.
   logic [DW-1:0] acc [NP];
   logic [DW-1:0] op  [NP];

   always_comb begin
      for (int i = 0; i < NP; i++) pe_c[i*DW +: DW] = acc[i];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NP; i++) acc[i] <= '0;
      end else if (pe_clr) begin
         for (int i = 0; i < NP; i++) acc[i] <= '0;
      end else if (in_valid && in_ready) begin
         for (int i = 0; i < NP; i++) acc[i] <= acc[i] + op[i];
      end
   end

   function automatic logic [DW-1:0] operand(input int kind, input int k, input int i);
      if (kind == 0) return (k == 0) ? DW'((i + 1) * 10) : '0;
      return DW'(kind) * 32'h0100_0000 + DW'(kind * 1000 + i * 100 + k * 7 + 1);
   endfunction

   logic [DW:0] sb_q [$];
   int pushed     = 0;
   int word_cnt   = 0;
   int tiles      = 0;
   int clr_cnt    = 0;
   int b2b_cnt    = 0;
   int stall_at   = -1;
   int stall_left = 0;

   // Output side: drives out_ready, checks words, hold stability and capture rules.
   initial begin
      logic          stall_prev;
      logic          cap_prev;
      logic [DW-1:0] prev_dat;
      logic          prev_last;
      logic [DW:0]   exp_w;
      stall_prev = 1'b0;
      cap_prev   = 1'b0;
      prev_dat   = '0;
      prev_last  = 1'b0;
      out_ready  = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst) begin
            stall_prev = 1'b0;
            cap_prev   = 1'b0;
            continue;
         end
         if (out_valid && word_cnt == stall_at && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = 1'b1;
         end
         #1;
         if (cap_prev) check("lat1_vld", out_valid, 1);
         if (stall_prev) begin
            check("hold_vld", out_valid, 1);
            check("hold_dat", out_data, prev_dat);
            check("hold_last", out_last, prev_last);
         end
         cap_prev = pe_clr;
         if (pe_clr) begin
            clr_cnt++;
            check("clr_free", !out_valid || (out_ready && out_last), 1);
            if (out_valid && out_ready && out_last) b2b_cnt++;
         end
         stall_prev = out_valid && !out_ready;
         prev_dat   = out_data;
         prev_last  = out_last;
         if (out_valid && out_ready) begin
            check("sb_pop", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
               exp_w = sb_q.pop_front();
               check("out_data", out_data, exp_w[DW-1:0]);
               check("out_last", out_last, exp_w[DW]);
            end
            word_cnt++;
         end
      end
   end

   // gaps: 4 bits per beat, idle cycles inserted before that beat.
   task automatic run_tile(input int kind, input int gaps, input bit hold, output int rdy_cyc);
      logic [DW-1:0] s;
      int to;
      for (int i = 0; i < NP; i++) begin
         s = '0;
         for (int k = 0; k < AL; k++) s = s + operand(kind, k, i);
         sb_q.push_back({(i == NP - 1), s});
      end
      pushed += NP;
      tiles++;
      rdy_cyc = 0;
      start = 1'b1;
      for (int k = 0; k < AL; k++) begin
         for (int g = 0; g < ((gaps >> (4 * k)) & 15); g++) begin
            in_valid = 1'b0;
            if (in_ready) rdy_cyc++;
            @(negedge clk);
         end
         in_valid = 1'b1;
         for (int i = 0; i < NP; i++) op[i] = operand(kind, k, i);
         to = 0;
         while (!in_ready && to < 64) begin
            @(negedge clk);
            to++;
         end
         if (!in_ready) begin
            check("beat_timeout", in_ready, 1);
            in_valid = 1'b0;
            start = 1'b0;
            return;
         end
         rdy_cyc++;
         @(negedge clk);
         check("beat_cnt", dut.beat_cnt, k + 1);
         if (!hold) start = 1'b0;
      end
      in_valid = 1'b0;
      for (int i = 0; i < NP; i++) op[i] = '0;
      check("rdy_cap", in_ready, 0);
      if (hold) begin
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int to;
      to = 0;
      while (sb_q.size() != 0 && to < 200) begin
         @(posedge clk);
         to++;
      end
      check("drain", sb_q.size(), 0);
      @(negedge clk);
      #2;
      check("idle_busy", busy, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int rc;
      int b2b0;
      int to;
      rst      = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < NP; i++) op[i] = '0;
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_pe_clr", pe_clr, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_beat_cnt", dut.beat_cnt, 0);
      check("rst_rd_idx", dut.rd_idx, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Basic tile: 10,20,30,40
      run_tile(0, 0, 1'b0, rc);
      check("t1_rdy_cycles", rc, AL);
      wait_drain();
      check("t1_clr_cnt", clr_cnt, 1);

      // Feeder gaps: valid pattern 1,0,0,1,0,1
      run_tile(1, 32'h120, 1'b0, rc);
      check("t2_rdy_cycles", rc, AL + 3);
      wait_drain();

      // Output backpressure on word 20 while a second tile waits in CAP
      b2b0 = b2b_cnt;
      stall_at = pushed + 1;
      stall_left = 5;
      run_tile(0, 0, 1'b0, rc);
      run_tile(2, 0, 1'b0, rc);
      @(negedge clk);
      #2;
      check("t3_cap_rdy", in_ready, 0);
      check("t3_cap_clr", pe_clr, 0);
      check("t3_stall_vld", out_valid, 1);
      check("t3_stall_dat", out_data, 20);
      check("t3_busy", busy, 1);
      wait_drain();
      check("t3_b2b", b2b_cnt - b2b0, 1);

      // Back-to-back: second capture coincides with the last word of the first
      b2b0 = b2b_cnt;
      stall_at = pushed;
      stall_left = 1;
      run_tile(3, 0, 1'b0, rc);
      run_tile(4, 0, 1'b0, rc);
      wait_drain();
      check("t4_b2b", b2b_cnt - b2b0, 1);

      // start held through RUN and a stalled CAP
      stall_at = pushed;
      stall_left = 8;
      run_tile(5, 0, 1'b0, rc);
      run_tile(8, 0, 1'b1, rc);
      wait_drain();
      check("t6_clr_cnt", clr_cnt, tiles);
      check("t6_in_ready", in_ready, 0);

      // Asynchronous reset mid-drain, after word 20 has left
      run_tile(6, 0, 1'b0, rc);
      to = 0;
      while (word_cnt < pushed - NP + 2 && to < 100) begin
         @(posedge clk);
         to++;
      end
      check("t5_reach", word_cnt >= pushed - NP + 2, 1);
      #3;
      rst = 1'b0;
      #1;
      check("t5_out_valid", out_valid, 0);
      check("t5_busy", busy, 0);
      check("t5_in_ready", in_ready, 0);
      check("t5_pe_clr", pe_clr, 0);
      check("t5_out_last", out_last, 0);
      sb_q.delete();
      word_cnt = pushed;
      stall_at = -1;
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      @(negedge clk);
      check("t5_idle_busy", busy, 0);
      check("t5_idle_rdy", in_ready, 0);
      check("t5_beat_cnt", dut.beat_cnt, 0);
      run_tile(7, 0, 1'b0, rc);
      check("t5_rdy_cycles", rc, AL);
      wait_drain();
      check("final_clr_cnt", clr_cnt, tiles);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
